// File: rtl/fir_conv_pkg.sv
// Shared types and width helpers for the streaming FIR convolver.
// Output width DW+CW+AW is enough for TAPS full-scale products, so the accumulator never wraps.
package fir_conv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAC  = 2'd1,
      ST_OUT  = 2'd2
   } state_e;

   function automatic int fir_aw(input int taps);
      return $clog2(taps);
   endfunction

   function automatic int fir_ow(input int dw, input int cw, input int taps);
      return dw + cw + fir_aw(taps);
   endfunction

endpackage

// File: rtl/fir_conv_stream_if.sv
// Bundle of sample/result handshakes, coefficient port and status for fir_conv_stream.
// Handshake: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
interface fir_conv_stream_if #(
   parameter int DW   = 2,
   parameter int CW   = 2,
   parameter int TAPS = 4
);
   import fir_conv_pkg::*;

   localparam int AW = fir_aw(TAPS);
   localparam int OW = fir_ow(DW, CW, TAPS);

   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [OW-1:0] out_data;
   logic          coef_we;
   logic [AW-1:0] coef_addr;
   logic [CW-1:0] coef_data;
   logic          clear;
   logic          busy;
   state_e        state_dbg;

   modport slave (
      input  in_valid, in_data, out_ready, coef_we, coef_addr, coef_data, clear,
      output in_ready, out_valid, out_data, busy, state_dbg
   );

   modport master (
      output in_valid, in_data, out_ready, coef_we, coef_addr, coef_data, clear,
      input  in_ready, out_valid, out_data, busy, state_dbg
   );

endinterface

// File: rtl/fir_conv_stream_mac_unit.sv
// Single multiply-accumulate slice: acc <= 0 on clr, acc <= acc + a*b on en.
module fir_mac_unit #(
   parameter int DW = 2,
   parameter int CW = 2,
   parameter int OW = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] a,
   input  logic [CW-1:0] b,
   input  logic          clr,
   input  logic          en,
   output logic [OW-1:0] acc
);

   logic [DW+CW-1:0] prod;
   logic [OW-1:0]    acc_q;
   logic [OW-1:0]    acc_d;

   assign prod = {{CW{1'b0}}, a} * {{DW{1'b0}}, b};

   always_comb begin
      acc_d = acc_q;
      if (clr) begin
         acc_d = '0;
      end else if (en) begin
         acc_d = acc_q + OW'(prod);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc = acc_q;

endmodule

// File: rtl/fir_conv_stream.sv
// Streaming FIR y[n] = sum h[k]*x[n-k] with one shared multiplier stepped over TAPS cycles.
// Delay line, coefficient file and the IDLE/MAC/OUT controller live here.
module fir_conv_stream #(
   parameter int DW   = 2,
   parameter int CW   = 2,
   parameter int TAPS = 4
) (
   input logic               clk,
   input logic               rst,
   fir_conv_stream_if.slave  bus
);
   import fir_conv_pkg::*;

   localparam int AW = fir_aw(TAPS);
   localparam int OW = fir_ow(DW, CW, TAPS);

   state_e        state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [DW-1:0] dly_q  [TAPS];
   logic [DW-1:0] dly_d  [TAPS];
   logic [CW-1:0] coef_q [TAPS];
   logic [CW-1:0] coef_d [TAPS];
   logic          accept;
   logic          mac_clr;
   logic          mac_en;
   logic [OW-1:0] acc;

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      dly_d         = dly_q;
      coef_d        = coef_q;
      accept        = 1'b0;
      mac_clr       = 1'b0;
      mac_en        = 1'b0;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // clear takes priority over a sample arriving in the same cycle
            bus.in_ready = !bus.clear;
            accept       = bus.in_valid && !bus.clear;
            if (bus.clear) begin
               for (int k = 0; k < TAPS; k++) dly_d[k] = '0;
            end else if (accept) begin
               dly_d[0] = bus.in_data;
               for (int k = 1; k < TAPS; k++) dly_d[k] = dly_q[k-1];
               mac_clr = 1'b1;
               idx_d   = '0;
               state_d = ST_MAC;
            end
            if (!accept && bus.coef_we && (int'(bus.coef_addr) < TAPS)) begin
               coef_d[bus.coef_addr] = bus.coef_data;
            end
         end
         ST_MAC: begin
            mac_en = 1'b1;
            idx_d  = idx_q + 1'b1;
            if (idx_q == AW'(TAPS - 1)) begin
               idx_d   = '0;
               state_d = ST_OUT;
            end
         end
         ST_OUT: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         for (int k = 0; k < TAPS; k++) begin
            dly_q[k]  <= '0;
            coef_q[k] <= '0;
         end
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         dly_q   <= dly_d;
         coef_q  <= coef_d;
      end
   end

   fir_mac_unit #(.DW(DW), .CW(CW), .OW(OW)) u_mac (
      .clk (clk),
      .rst (rst),
      .a   (dly_q[idx_q]),
      .b   (coef_q[idx_q]),
      .clr (mac_clr),
      .en  (mac_en),
      .acc (acc)
   );

   // acc only moves during MAC, so it is stable for the whole OUT phase
   assign bus.out_data  = acc;
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.state_dbg = state_q;

endmodule
